// File: rtl/vec_logic_pkg.sv
// rtl/vec_logic_pkg.sv - shared op/state encodings and the per-bit logic op
package vec_logic_pkg;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-level so callers of any WIDTH can apply it per bit without
    // width extension; NAND is therefore the full-width inverse of AND.
    function automatic logic vec_op(input logic [1:0] op, input logic x, input logic y);
        logic r;
        case (op)
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            default: r = ~(x & y);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vec_logic_stage.sv
// rtl/vec_logic_stage.sv - one registered pipeline stage carrying {valid, last, op, vec}
// Ports: clk, rst_n (async active-low); *_i stage inputs; *_o registered outputs.
module vec_logic_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] vec_i,
    output logic             valid_o,
    output logic             last_o,
    output logic [1:0]       op_o,
    output logic [WIDTH-1:0] vec_o
);

    logic             valid_q;
    logic             last_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            op_q    <= 2'd0;
            vec_q   <= '0;
        end else begin
            valid_q <= valid_i;
            last_q  <= last_i;
            op_q    <= op_i;
            vec_q   <= vec_i;
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign op_o    = op_q;
    assign vec_o   = vec_q;

endmodule

// File: rtl/vec_logic_pipe.sv
// rtl/vec_logic_pipe.sv - LAT-stage bitwise logic pipeline with per-packet accumulator
// Ports: clk, rst_n (async active-low); in_valid/in_last/op/a/b input beat;
// out_valid/out_last/out_vec/out_all/out_any final-stage beat;
// acc_valid/acc_vec/beat_cnt/acc_ovf completed-packet result.
module vec_logic_pipe
    import vec_logic_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LAT       = 2,
    parameter int MAX_BEATS = 15,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             out_last,
    output logic [WIDTH-1:0] out_vec,
    output logic             out_all,
    output logic             out_any,
    output logic             acc_valid,
    output logic [WIDTH-1:0] acc_vec,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             acc_ovf
);

    logic [WIDTH-1:0] in_res;

    always_comb begin
        in_res = '0;
        for (int i = 0; i < WIDTH; i++) begin
            in_res[i] = vec_op(op, a[i], b[i]);
        end
    end

    // Index 0 is the raw input beat; index LAT is the final stage.
    logic             stg_valid [0:LAT];
    logic             stg_last  [0:LAT];
    logic [1:0]       stg_op    [0:LAT];
    logic [WIDTH-1:0] stg_vec   [0:LAT];

    assign stg_valid[0] = in_valid;
    assign stg_last[0]  = in_last;
    assign stg_op[0]    = op;
    assign stg_vec[0]   = in_res;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        vec_logic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (stg_valid[s]),
            .last_i  (stg_last[s]),
            .op_i    (stg_op[s]),
            .vec_i   (stg_vec[s]),
            .valid_o (stg_valid[s+1]),
            .last_o  (stg_last[s+1]),
            .op_o    (stg_op[s+1]),
            .vec_o   (stg_vec[s+1])
        );
    end

    assign out_valid = stg_valid[LAT];
    assign out_last  = stg_last[LAT];
    assign out_vec   = stg_vec[LAT];
    // Reductions of the final-stage register, so they align with out_vec.
    assign out_all   = &stg_vec[LAT];
    assign out_any   = |stg_vec[LAT];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_vec_q, acc_vec_d;
    logic [1:0]       acc_op_q, acc_op_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             acc_ovf_q, acc_ovf_d;

    logic [WIDTH-1:0] fold_vec;
    logic [1:0]       start_op;

    always_comb begin
        fold_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fold_vec[i] = vec_op(acc_op_q, acc_vec_q[i], out_vec[i]);
        end
    end

    // A NAND packet folds later beats with AND; only the first beat is inverted.
    assign start_op = (stg_op[LAT] == OP_NAND) ? OP_AND : stg_op[LAT];

    always_comb begin
        state_d    = state_q;
        acc_vec_d  = acc_vec_q;
        acc_op_d   = acc_op_q;
        beat_cnt_d = beat_cnt_q;
        acc_ovf_d  = acc_ovf_q;
        case (state_q)
            // DONE shares the IDLE load so a beat right after a packet's last is kept.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (out_valid) begin
                    acc_vec_d  = out_vec;
                    acc_op_d   = start_op;
                    beat_cnt_d = CNT_W'(1);
                    acc_ovf_d  = 1'b0;
                    state_d    = out_last ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                if (out_valid) begin
                    acc_vec_d = fold_vec;
                    if (beat_cnt_q == CNT_W'(MAX_BEATS)) begin
                        acc_ovf_d = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    if (out_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_vec_q  <= '0;
            acc_op_q   <= OP_AND;
            beat_cnt_q <= '0;
            acc_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_vec_q  <= acc_vec_d;
            acc_op_q   <= acc_op_d;
            beat_cnt_q <= beat_cnt_d;
            acc_ovf_q  <= acc_ovf_d;
        end
    end

    assign acc_valid = (state_q == ST_DONE);
    assign acc_vec   = acc_vec_q;
    assign beat_cnt  = beat_cnt_q;
    assign acc_ovf   = acc_ovf_q;

endmodule
